decode_seq: RTL and testbench

//   Instruction fetch/decode timing sequencer for the MOSby core; sits directly upstream of the branch unit.

---
 rtl/decode_seq.sv | 103 ++++++++++
 tb/tb_decode_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_seq.sv
// Fetch/decode T-state sequencer for NOP, relative branches and JMP abs.
// Latches the opcode in T0 and emits rdy/rst-gated Moore strobes toward the branch/PC path.
module decode_seq #(
  parameter logic [7:0] NOP_OPC = 8'hEA,
  parameter logic [7:0] JMP_OPC = 8'h4C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] data_bus,
  output logic [7:0] opcode,
  output logic       sync,
  output logic       pc_inc_decoder,
  output logic       branch_con,
  output logic [2:0] branch_op,
  output logic       branch_uncon,
  output logic       lower_byte_decoder,
  output logic       illegal
);

  typedef enum logic [1:0] {
    S_RST = 2'd0,
    S_T0  = 2'd1,
    S_T1  = 2'd2,
    S_T2  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] opcode_q;

  logic       sync_raw;
  logic       pc_inc_raw;
  logic       branch_con_raw;
  logic [2:0] branch_op_raw;
  logic       branch_uncon_raw;
  logic       lower_raw;
  logic       illegal_raw;
  logic       active;
  logic       is_branch;

  assign is_branch = (opcode_q[4:0] == 5'b10000);
  assign active    = rdy & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RST;
      opcode_q <= NOP_OPC;
    end else if (rdy) begin
      state <= state_next;
      if (state == S_T0) opcode_q <= data_bus;
    end
  end

  always_comb begin
    state_next       = state;
    sync_raw         = 1'b0;
    pc_inc_raw       = 1'b0;
    branch_con_raw   = 1'b0;
    branch_op_raw    = 3'b000;
    branch_uncon_raw = 1'b0;
    lower_raw        = 1'b0;
    illegal_raw      = 1'b0;
    case (state)
      S_RST: state_next = S_T0;
      S_T0: begin
        sync_raw   = 1'b1;
        pc_inc_raw = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        state_next = S_T0;
        // Class is taken from the latched opcode only, never from the live bus.
        if (is_branch) begin
          branch_con_raw = 1'b1;
          branch_op_raw  = opcode_q[7:5];
          pc_inc_raw     = 1'b1;
        end else if (opcode_q == JMP_OPC) begin
          lower_raw  = 1'b1;
          pc_inc_raw = 1'b1;
          state_next = S_T2;
        end else if (opcode_q != NOP_OPC) begin
          illegal_raw = 1'b1;
        end
      end
      S_T2: begin
        branch_uncon_raw = 1'b1;
        state_next       = S_T0;
      end
      default: state_next = S_RST;
    endcase
  end

  assign opcode             = rst ? opcode_q : 8'h00;
  assign sync               = sync_raw & active;
  assign pc_inc_decoder     = pc_inc_raw & active;
  assign branch_con         = branch_con_raw & active;
  assign branch_op          = branch_op_raw & {3{active}};
  assign branch_uncon       = branch_uncon_raw & active;
  assign lower_byte_decoder = lower_raw & active;
  assign illegal            = illegal_raw & active;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level timing table.
module tb_decode_seq;

  localparam logic [7:0] NOP = 8'hEA;
  localparam logic [7:0] JMP = 8'h4C;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [7:0] data_bus;
  logic [7:0] opcode;
  logic       sync;
  logic       pc_inc_decoder;
  logic       branch_con;
  logic [2:0] branch_op;
  logic       branch_uncon;
  logic       lower_byte_decoder;
  logic       illegal;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_op;

  always #5 clk = ~clk;

  decode_seq dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .data_bus(data_bus),
    .opcode(opcode),
    .sync(sync),
    .pc_inc_decoder(pc_inc_decoder),
    .branch_con(branch_con),
    .branch_op(branch_op),
    .branch_uncon(branch_uncon),
    .lower_byte_decoder(lower_byte_decoder),
    .illegal(illegal)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output vector: [8]sync [7]pc_inc [6]branch_con [5:3]branch_op [2]branch_uncon [1]lower [0]illegal
  function automatic logic [8:0] obs_vec();
    return {sync, pc_inc_decoder, branch_con, branch_op, branch_uncon, lower_byte_decoder, illegal};
  endfunction

  function automatic int instr_len(input logic [7:0] op);
    return (op == JMP) ? 3 : 2;
  endfunction

  // Expected strobes for cycle k of an instruction with opcode op, run with rdy=1.
  function automatic logic [8:0] exp_vec(input logic [7:0] op, input int k);
    logic [8:0] v;
    v = '0;
    if (k == 0) begin
      v[8] = 1'b1;
      v[7] = 1'b1;
    end else if (k == 1) begin
      if (op[4:0] == 5'b10000) begin
        v[6]   = 1'b1;
        v[5:3] = op[7:5];
        v[7]   = 1'b1;
      end else if (op == JMP) begin
        v[1] = 1'b1;
        v[7] = 1'b1;
      end else if (op != NOP) begin
        v[0] = 1'b1;
      end
    end else begin
      v[2] = 1'b1;
    end
    return v;
  endfunction

  task automatic step_check(input string tag, input logic [8:0] ev, input logic [7:0] eop);
    @(negedge clk);
    check_val(tag, {7'b0, obs_vec()}, {7'b0, ev});
    check_val({tag, "_opc"}, {8'b0, opcode}, {8'b0, eop});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int low_cycles);
    rst = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      rdy      = 1'($urandom_range(0, 1));
      data_bus = 8'($urandom);
      step_check("rst_low", 9'b0, 8'h00);
    end
    rst      = 1'b1;
    rdy      = 1'b1;
    data_bus = NOP;
    step_check("rst_release", 9'b0, NOP);
    last_op = NOP;
  endtask

  // Runs one instruction; optional fixed stall of fix_n cycles before phase fix_k,
  // optional random stalls up to stall_max, optional reset abort at phase abort_k.
  task automatic run_instr(input logic [7:0] op, input int stall_max,
                           input int fix_k, input int fix_n, input int abort_k);
    int         n;
    logic [7:0] cur;
    for (int k = 0; k < instr_len(op); k++) begin
      cur = (k == 0) ? last_op : op;
      if (k == abort_k) begin
        rst      = 1'b0;
        rdy      = 1'b1;
        data_bus = 8'($urandom);
        step_check("abort", 9'b0, 8'h00);
        rst      = 1'b1;
        data_bus = 8'($urandom);
        step_check("abort_rst", 9'b0, NOP);
        last_op = NOP;
        return;
      end
      n = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
      if (k == fix_k) n = fix_n;
      for (int s = 0; s < n; s++) begin
        rdy      = 1'b0;
        data_bus = 8'($urandom);
        step_check("stall", 9'b0, cur);
      end
      rdy      = 1'b1;
      data_bus = (k == 0) ? op : 8'($urandom);
      step_check($sformatf("op%02h_t%0d", op, k), exp_vec(op, k), cur);
    end
    last_op = op;
  endtask

  initial begin
    logic [7:0] branches [8];
    logic [7:0] op;
    branches = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0};
    rst      = 1'b0;
    rdy      = 1'b1;
    data_bus = NOP;
    last_op  = NOP;
    @(posedge clk);
    #1;

    do_reset(2);
    // First T0 after reset, then the directed instruction classes.
    run_instr(8'hF0, 0, -1, 0, -1);
    for (int i = 0; i < 8; i++) run_instr(branches[i], 0, -1, 0, -1);
    run_instr(JMP, 0, -1, 0, -1);
    run_instr(NOP, 0, -1, 0, -1);
    run_instr(8'h02, 0, -1, 0, -1);
    run_instr(JMP, 0, 2, 3, -1);
    run_instr(8'h50, 0, -1, 0, 1);
    run_instr(NOP, 0, -1, 0, -1);
    do_reset(1);
    run_instr(JMP, 0, -1, 0, 2);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: op = branches[$urandom_range(0, 7)];
        1: op = JMP;
        2: op = NOP;
        default: op = 8'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0)
        run_instr(op, 2, -1, 0, $urandom_range(0, instr_len(op) - 1));
      else
        run_instr(op, 2, -1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
